// File: rtl/board_judge.sv
// Sequential tic-tac-toe judge: snapshots the board, scans one line per clock, then checks for a draw.
// Define BOARD_JUDGE_EARLY_EXIT_EN to leave the scan at the first winning line.
module board_judge (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] board,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [3:0]  win_line
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        FULLCHK = 2'd2,
        REPORT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;           // 0-7: line under test, 8: scan drained
    logic        hit_q, hit_d;
    logic [1:0]  hit_code_q, hit_code_d;
    logic [3:0]  hit_line_q, hit_line_d;
    logic        won_q, won_d;
    logic [1:0]  result_q, result_d;
    logic [3:0]  win_line_q, win_line_d;

    logic [1:0]  t0, t1, t2;
    logic        line_hit;
    logic        board_full;

    function automatic logic [1:0] tile_of(input logic [17:0] b, input logic [3:0] t);
        return b[{t, 1'b0} +: 2];
    endfunction

    function automatic logic [11:0] line_tiles(input logic [2:0] l);
        case (l)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Line evaluation and fullness test, both on the snapshot only.
    always_comb begin
        logic [11:0] sel;
        sel        = line_tiles(idx_q[2:0]);
        t0         = tile_of(snap_q, sel[11:8]);
        t1         = tile_of(snap_q, sel[7:4]);
        t2         = tile_of(snap_q, sel[3:0]);
        line_hit   = (state_q == SCAN) && !idx_q[3] && (t0 == t1) && (t1 == t2)
                     && ((t0 == 2'd1) || (t0 == 2'd2));
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!(tile_of(snap_q, 4'(i)) inside {2'd1, 2'd2})) board_full = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: each combinational block assigns a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
`ifdef BOARD_JUDGE_EARLY_EXIT_EN
                if (hit_q)         state_d = REPORT;
                else if (idx_q[3]) state_d = FULLCHK;
`else
                if (idx_q[3])      state_d = FULLCHK;
`endif
            end
            FULLCHK: state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == REPORT);
        result   = result_q;
        win_line = win_line_q;
    end

    // A line's verdict is registered in hit_q and acted on one edge later.
    always_comb begin
        snap_d     = snap_q;
        idx_d      = idx_q;
        hit_d      = 1'b0;
        hit_code_d = hit_code_q;
        hit_line_d = hit_line_q;
        won_d      = won_q;
        result_d   = result_q;
        win_line_d = win_line_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = board;
                    idx_d      = 4'd0;
                    won_d      = 1'b0;
                    result_d   = 2'd0;
                    win_line_d = 4'hF;
                end
            end
            SCAN: begin
                if (!idx_q[3]) idx_d = idx_q + 4'd1;
                hit_d      = line_hit;
                hit_code_d = t0;
                hit_line_d = idx_q;
                if (hit_q && !won_q) begin
                    result_d   = hit_code_q;
                    win_line_d = hit_line_q;
                    won_d      = 1'b1;
                end
            end
            FULLCHK: begin
                if (!won_q) begin
                    result_d   = board_full ? 2'd3 : 2'd0;
                    win_line_d = 4'hF;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the snapshot is reset along with the control state so an aborted board never lingers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q     <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_code_q <= '0;
            hit_line_q <= '0;
            won_q      <= 1'b0;
            result_q   <= 2'd0;
            win_line_q <= 4'hF;
        end else begin
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            hit_code_q <= hit_code_d;
            hit_line_q <= hit_line_d;
            won_q      <= won_d;
            result_q   <= result_d;
            win_line_q <= win_line_d;
        end
    end

endmodule
